// File: rtl/arb32_sched.sv
// 32-requester round-robin arbiter with registered one-hot grant and a hold limit.
// A grant is held until done, loss of its request, or MAX_HOLD cycles, whichever comes first.
module arb32_sched #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] req,
  input  logic        done,
  output logic [31:0] gnt,
  output logic [4:0]  gnt_id,
  output logic        gnt_vld,
  output logic        any_req,
  output logic        timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t      state_q;
  logic [4:0]  ptr_q;
  logic [7:0]  hold_q;
  logic [31:0] gnt_q;
  logic [4:0]  gnt_id_q;
  logic        gnt_vld_q;
  logic        timeout_q;
  logic        any_req_q;

  logic [31:0] hi_mask;
  logic [31:0] hi_req;
  logic [31:0] pick_vec;
  logic [4:0]  sel_id_d;
  logic        rel_drop;
  logic        rel_max;
  logic        release_d;
  logic        timeout_d;

  // Requests at or above the pointer take priority over the wrapped-around ones.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_mask
      assign hi_mask[gi] = (5'(gi) >= ptr_q);
    end
  endgenerate

  assign hi_req = req & hi_mask;

  always_comb begin
    pick_vec = (|hi_req) ? hi_req : req;
    sel_id_d = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pick_vec[i]) sel_id_d = 5'(i);
    end
  end

  assign rel_drop  = ~req[gnt_id_q];
  assign rel_max   = (hold_q == MAX_HOLD_C);
  assign release_d = done | rel_drop | rel_max;
  // Forced release only when the hold limit is the sole cause.
  assign timeout_d = rel_max & ~done & ~rel_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
      any_req_q <= 1'b0;
    end else begin
      any_req_q <= |req;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && (|req)) begin
            gnt_q     <= 32'd1 << sel_id_d;
            gnt_id_q  <= sel_id_d;
            gnt_vld_q <= 1'b1;
            hold_q    <= 8'd1;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (release_d) begin
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            hold_q    <= '0;
            ptr_q     <= gnt_id_q + 5'd1;
            timeout_q <= timeout_d;
            state_q   <= IDLE;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
  assign any_req = any_req_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb32_sched.sv
// Directed scenarios plus randomized traffic, each cycle checked against a
// round-robin reference model computed from the arbitration rules.
module tb_arb32_sched;

  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] req = '0;
  logic        done = 1'b0;
  logic [31:0] gnt;
  logic [4:0]  gnt_id;
  logic        gnt_vld;
  logic        any_req;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_busy = 0;
  int m_ptr = 0;
  int m_id = 0;
  int m_hold = 0;
  bit m_to = 0;
  bit m_any = 0;

  arb32_sched #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld),
    .any_req(any_req), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit drop, lim;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_id = 0; m_hold = 0; m_to = 0; m_any = 0;
    end else begin
      m_any = (req != 0);
      m_to = 0;
      if (!m_busy) begin
        if (en && req != 0) begin
          for (int k = 0; k < 32; k++) begin
            if (req[(m_ptr + k) % 32]) begin
              m_id = (m_ptr + k) % 32;
              break;
            end
          end
          m_busy = 1;
          m_hold = 1;
        end
      end else begin
        drop = !req[m_id];
        lim = (m_hold == MAXH);
        if (done || drop || lim) begin
          m_to = lim && !done && !drop;
          m_busy = 0;
          m_ptr = (m_id + 1) % 32;
          m_hold = 0;
        end else begin
          m_hold++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("gnt", gnt, m_busy ? (32'd1 << m_id) : 32'd0);
    chk("gnt_id", 32'(gnt_id), m_busy ? 32'(m_id) : 32'd0);
    chk("gnt_vld", 32'(gnt_vld), 32'(m_busy));
    chk("any_req", 32'(any_req), 32'(m_any));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = '0; done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int order28 [4] = '{0, 7, 0, 7};
    int order29 [3] = '{0, 31, 0};
    int n;

    // reset state
    do_reset();
    chk("reset_gnt", gnt, 32'd0);
    chk("reset_vld", 32'(gnt_vld), 32'd0);

    // alternating pair 0/7 with done three cycles after each grant
    en = 1'b1; req = 32'h0000_0081;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("rr07_id", 32'(gnt_id), 32'(order28[g]));
      chk("rr07_vld", 32'(gnt_vld), 32'd1);
      step(); step();
      done = 1'b1; step(); done = 1'b0;
      chk("rr07_gap", 32'(gnt_vld), 32'd0);
    end

    // wrap from 31 back to 0
    do_reset();
    en = 1'b1; req = 32'h8000_0001;
    for (int g = 0; g < 3; g++) begin
      step();
      chk("wrap_gnt", gnt, 32'd1 << order29[g]);
      done = 1'b1; step(); done = 1'b0;
    end

    // hold limit forces release with a timeout pulse
    do_reset();
    en = 1'b1; req = 32'h0000_0020;
    step();
    n = 0;
    while (gnt_vld && n < 20) begin
      chk("hold_gnt", gnt, 32'h20);
      n++;
      step();
    end
    chk("hold_len", 32'(n), 32'(MAXH));
    chk("hold_to", 32'(timeout), 32'd1);
    step();
    chk("regrant", gnt, 32'h20);
    chk("to_pulse", 32'(timeout), 32'd0);

    // done on the last hold cycle is a normal release
    step(); step(); step();
    done = 1'b1; step(); done = 1'b0;
    chk("done_max_vld", 32'(gnt_vld), 32'd0);
    chk("done_max_to", 32'(timeout), 32'd0);

    // reset in the middle of a grant
    do_reset();
    en = 1'b1; req = 32'h0000_0008;
    step();
    chk("g3_id", 32'(gnt_id), 32'd3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_gnt", gnt, 32'd0);
    chk("mid_rst_any", 32'(any_req), 32'd0);
    step();
    chk("post_rst_gnt", gnt, 32'h8);

    // enable gating
    do_reset();
    en = 1'b0; req = 32'hFFFF_FFFF;
    step();
    chk("en0_any", 32'(any_req), 32'd1);
    chk("en0_gnt", gnt, 32'd0);
    step();
    chk("en0_gnt2", gnt, 32'd0);
    en = 1'b1; step();
    chk("en1_gnt", gnt, 32'd1);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req = '0;
          1: req = 32'd1 << $urandom_range(0, 31);
          2: req = $urandom & $urandom & $urandom;
          default: req = $urandom;
        endcase
      end
      done = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb32_sched.md
ARB32_SCHED -- requirements
Module: arb32_sched

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum grant duration in cycles before a forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  arbitration enable; 0 blocks new grants only.
REQ-005 req  input  32  per-requester request, bit i = requester i.
REQ-006 done  input  1  shared resource finished current transaction.
REQ-007 gnt  output  32  registered one-hot grant, or all-zero.
REQ-008 gnt_id  output  5  index of granted requester; 0 when gnt is zero.
REQ-009 gnt_vld  output  1  registered, equals OR of gnt.
REQ-010 any_req  output  1  registered OR-reduction of req (32-to-1 fan-in), one-cycle latency.
REQ-011 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 FSM states: IDLE, BUSY; no other reachable state.
REQ-013 IDLE: if en=1 and any req bit set, select the lowest index i >= ptr with req[i]=1, else wrap and select the lowest index < ptr; register gnt, gnt_id and gnt_vld; enter BUSY.
REQ-014 Grant latency: req sampled at edge N -> gnt visible after edge N+1 (one cycle).
REQ-015 BUSY: gnt held constant; hold counter increments each cycle from 1.
REQ-016 Release conditions, evaluated each BUSY cycle: done=1; or req[gnt_id]=0; or hold counter = MAX_HOLD.
REQ-017 On release: gnt, gnt_id and gnt_vld cleared at the next edge; ptr = (gnt_id+1) mod 32; hold counter cleared; state returns to IDLE.
REQ-018 After release, gnt_vld SHALL be 0 for at least one cycle; the earliest new grant is two cycles after the cycle in which done was sampled.
REQ-019 timeout pulses for exactly one cycle, coincident with the gnt-clear edge, only when release is caused solely by the hold counter reaching MAX_HOLD.
REQ-020 done=1 in the same cycle as hold counter = MAX_HOLD: release counts as normal; no timeout pulse.
REQ-021 done=1 while in IDLE: ignored.
REQ-022 en=0 while in BUSY: current grant continues until a release condition; no new grant is issued while en=0.
REQ-023 ptr wrap: after gnt_id=31 is released, ptr=0.
REQ-024 gnt SHALL never have more than one bit set; gnt_id SHALL always match the set bit.
REQ-025 any_req is independent of en and the FSM state.

Reset
REQ-026 rst=1 at any edge, including mid-BUSY: next state IDLE; ptr=0; hold counter=0; gnt=0; gnt_id=0; gnt_vld=0; timeout=0; any_req=0.
REQ-027 rst has priority over every other input; the first grant after reset deasserts SHALL start from ptr=0.

Verification
REQ-028 Reset, then en=1, req=0x0000_0081 held, done pulsed 3 cycles after each grant -> grant order 0,7,0,7; gnt_vld low for 1 cycle between grants.
REQ-029 Reset, then en=1, req=0x8000_0001 -> gnt=0x1 (ptr=0); after done -> gnt=0x8000_0000; after done -> ptr wraps to 0 and gnt=0x1.
REQ-030 MAX_HOLD=4, req[5]=1 held, done never asserted -> gnt=0x20 for exactly 4 cycles; timeout pulses once; the requester is re-granted after a 1-cycle gap.
REQ-031 MAX_HOLD=4, done=1 on the 4th hold cycle -> release with timeout=0.
REQ-032 Grant to requester 3 active, rst=1 for 1 cycle -> all outputs 0 next cycle; with req=0x8 still set, the next grant is 3, issued 1 cycle after rst drops.
REQ-033 en=0, req=0xFFFF_FFFF -> any_req=1 one cycle later and gnt stays 0; en=1 -> gnt=0x1 one cycle later.
